sram_mem_ctrl: RTL and testbench

- Memory-stage responder for the pipeline's data-memory requests (`mem_read_en` / `mem_write_en`).
- Converts each 32-bit word access into two sequential 16-bit accesses on an external asynchronous SRAM.
- Asserts `stall` to freeze the pipeline while an access is in flight.
- Sits between the EXE/MEM pipeline register and the board SRAM pins.

---
 rtl/sram_mem_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl
// Memory-stage responder that splits each 32-bit data-memory access into two
// sequential 16-bit accesses on an external asynchronous SRAM. The pipeline
// is frozen with `stall` while an access is in flight.
//
// Optional feature macro: SRAM_CTRL_POSTED_WRITE_EN
//   When defined, a write seen in IDLE completes towards the pipeline at once
//   (stall=0, ready=1 in that cycle) and the SRAM write runs in the
//   background. The FSM then goes LOW -> HIGH -> IDLE without a DONE cycle.
//
// Parameters:
//   WAIT_CYCLES  extra SRAM cycles per half access (0..7)
//   BASE_ADDR    byte address mapped to SRAM half-word 0
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mem_read_en    read request (level, held while stall=1)
//   mem_write_en   write request (level, held while stall=1)
//   address        byte address, bits [1:0] ignored
//   write_data     store data
//   read_data      loaded word, registered
//   ready          one-cycle completion pulse
//   stall          pipeline freeze (combinational)
//   sram_addr      SRAM half-word address
//   sram_dq_out    write data to pad
//   sram_dq_in     read data from pad
//   sram_dq_oe     pad output enable
//   sram_we_n      SRAM write strobe, active-low
module sram_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        stall,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;
    logic [16:0] word_r;
    logic [31:0] wdata_r;
    logic        is_write_r;
    logic        ready_r;

    logic        req_s;
    logic        last_s;
    logic [31:0] offset_s;
    logic        unused_offset_bits_s;

    logic        acc_write_s;
    logic [16:0] acc_word_s;
    logic [31:0] acc_data_s;
    logic        half_s;

    logic [17:0] addr_nxt_s;
    logic [15:0] dq_out_nxt_s;
    logic        oe_nxt_s;
    logic        we_n_nxt_s;

    assign req_s    = mem_read_en | mem_write_en;
    assign last_s   = (cnt_r == LAST_CNT);
    assign offset_s = address - BASE_ADDR;
    // Only offset bits [18:2] form the SRAM word address.
    assign unused_offset_bits_s = ^{offset_s[31:19], offset_s[1:0]};

    // In IDLE the access about to start comes straight from the request
    // inputs; afterwards it comes from the values captured at the IDLE edge.
    assign acc_write_s = (state_r == ST_IDLE) ? mem_write_en : is_write_r;
    assign acc_word_s  = (state_r == ST_IDLE) ? offset_s[18:2] : word_r;
    assign acc_data_s  = (state_r == ST_IDLE) ? write_data : wdata_r;

    // Next-state and phase-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 3'd0;
                if (req_s) begin
                    state_nxt_s = ST_LOW;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (last_s) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = 3'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 3'd1;
                end
            end
            ST_HIGH: begin
                if (last_s) begin
`ifdef SRAM_CTRL_POSTED_WRITE_EN
                    // Posted writes were already acknowledged in IDLE.
                    if (is_write_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
`else
                    state_nxt_s = ST_DONE;
`endif
                    cnt_nxt_s = 3'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 3'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 3'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // Pad values for the coming cycle, so the pins leave flops directly.
    always_comb begin
        addr_nxt_s   = sram_addr;
        dq_out_nxt_s = sram_dq_out;
        oe_nxt_s     = 1'b0;
        we_n_nxt_s   = 1'b1;
        half_s       = (state_nxt_s == ST_HIGH);
        if ((state_nxt_s == ST_LOW) || (state_nxt_s == ST_HIGH)) begin
            addr_nxt_s = {acc_word_s, half_s};
            if (acc_write_s) begin
                oe_nxt_s     = 1'b1;
                dq_out_nxt_s = half_s ? acc_data_s[31:16] : acc_data_s[15:0];
                // The final cycle of a multi-cycle phase is a hold with we_n
                // high; a single-cycle phase strobes for its only cycle.
                if ((LAST_CNT != 3'd0) && (cnt_nxt_s == LAST_CNT)) begin
                    we_n_nxt_s = 1'b1;
                end else begin
                    we_n_nxt_s = 1'b0;
                end
            end else begin
                oe_nxt_s   = 1'b0;
                we_n_nxt_s = 1'b1;
            end
        end else begin
            oe_nxt_s   = 1'b0;
            we_n_nxt_s = 1'b1;
        end
    end

    // State, counter and registered pad outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            ready_r     <= 1'b0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ready_r     <= (state_nxt_s == ST_DONE);
            sram_addr   <= addr_nxt_s;
            sram_dq_out <= dq_out_nxt_s;
            sram_dq_oe  <= oe_nxt_s;
            sram_we_n   <= we_n_nxt_s;
        end
    end

    // Capture of the access when it leaves IDLE; a write wins over a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r     <= 17'd0;
            wdata_r    <= 32'd0;
            is_write_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            word_r     <= offset_s[18:2];
            wdata_r    <= write_data;
            is_write_r <= mem_write_en;
        end else begin
            word_r     <= word_r;
            wdata_r    <= wdata_r;
            is_write_r <= is_write_r;
        end
    end

    // Read data is sampled from the pad on the last cycle of each read phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= 32'd0;
        end else if ((state_r == ST_LOW) && last_s && !is_write_r) begin
            read_data[15:0] <= sram_dq_in;
        end else if ((state_r == ST_HIGH) && last_s && !is_write_r) begin
            read_data[31:16] <= sram_dq_in;
        end else begin
            read_data <= read_data;
        end
    end

`ifdef SRAM_CTRL_POSTED_WRITE_EN
    // Writes accepted in IDLE are acknowledged in the same cycle.
    assign ready = ready_r | ((state_r == ST_IDLE) & mem_write_en);
    assign stall = req_s & (state_r != ST_DONE) & ~((state_r == ST_IDLE) & mem_write_en);
`else
    assign ready = ready_r;
    assign stall = req_s & (state_r != ST_DONE);
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
module tb_sram_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        stall;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Simple asynchronous SRAM model, with a preload port for the bench.
    logic [15:0] sram_mem [0:262143];
    logic        preload_en;
    logic [17:0] preload_addr;
    logic [15:0] preload_data;

    always @(posedge clk) begin
        if (preload_en) begin
            sram_mem[preload_addr] <= preload_data;
        end else if (sram_dq_oe && !sram_we_n) begin
            sram_mem[sram_addr] <= sram_dq_out;
        end
    end

    assign sram_dq_in = sram_mem[sram_addr];

    sram_mem_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read_en (mem_read_en),
        .mem_write_en(mem_write_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .stall       (stall),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        tick();
        preload_en   = 1'b0;
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        address      = 32'd0;
        write_data   = 32'd0;
        preload_en   = 1'b0;
        preload_addr = 18'd0;
        preload_data = 16'd0;

        // Reset values
        tick();
        check("rst_read_data", read_data, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Word at SRAM half-words 6/7 for a pure read pattern
        preload(18'd6, 16'h1234);
        preload(18'd7, 16'h5678);
        tick();

`ifndef SRAM_CTRL_POSTED_WRITE_EN
        // Blocking write 0xDEADBEEF to 1032
        address = 32'd1032; write_data = 32'hDEADBEEF; mem_write_en = 1'b1;
        #1;
        check("wr_c0_stall", {31'd0, stall}, 32'd1);
        check("wr_c0_ready", {31'd0, ready}, 32'd0);
        tick();
        check("wr_c1_addr", {14'd0, sram_addr}, 32'd4);
        check("wr_c1_dq", {16'd0, sram_dq_out}, 32'h0000BEEF);
        check("wr_c1_oe", {31'd0, sram_dq_oe}, 32'd1);
        check("wr_c1_we_n", {31'd0, sram_we_n}, 32'd0);
        check("wr_c1_stall", {31'd0, stall}, 32'd1);
        tick();
        check("wr_c2_addr", {14'd0, sram_addr}, 32'd4);
        check("wr_c2_we_n", {31'd0, sram_we_n}, 32'd1);
        check("wr_c2_oe", {31'd0, sram_dq_oe}, 32'd1);
        tick();
        check("wr_c3_addr", {14'd0, sram_addr}, 32'd5);
        check("wr_c3_dq", {16'd0, sram_dq_out}, 32'h0000DEAD);
        check("wr_c3_we_n", {31'd0, sram_we_n}, 32'd0);
        tick();
        check("wr_c4_we_n", {31'd0, sram_we_n}, 32'd1);
        check("wr_c4_stall", {31'd0, stall}, 32'd1);
        check("wr_c4_ready", {31'd0, ready}, 32'd0);
        tick();
        check("wr_c5_ready", {31'd0, ready}, 32'd1);
        check("wr_c5_stall", {31'd0, stall}, 32'd0);
        mem_write_en = 1'b0;
        tick();
        check("wr_c6_ready", {31'd0, ready}, 32'd0);
        check("wr_c6_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("wr_c6_we_n", {31'd0, sram_we_n}, 32'd1);
        check("wr_c6_addr_hold", {14'd0, sram_addr}, 32'd5);
        check("wr_mem_lo", {16'd0, sram_mem[4]}, 32'h0000BEEF);
        check("wr_mem_hi", {16'd0, sram_mem[5]}, 32'h0000DEAD);

        // Read back from 1032
        address = 32'd1032; mem_read_en = 1'b1;
        #1;
        check("rd_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        check("rd_c1_addr", {14'd0, sram_addr}, 32'd4);
        check("rd_c1_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rd_c1_we_n", {31'd0, sram_we_n}, 32'd1);
        tick(); tick();
        check("rd_c3_addr", {14'd0, sram_addr}, 32'd5);
        tick(); tick();
        check("rd_c5_ready", {31'd0, ready}, 32'd1);
        check("rd_c5_stall", {31'd0, stall}, 32'd0);
        check("rd_c5_data", read_data, 32'hDEADBEEF);
        mem_read_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rd_hold_data", read_data, 32'hDEADBEEF);
        end
`endif

        // Read of the preloaded word at 1036
        address = 32'd1036; mem_read_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rd2_c5_ready", {31'd0, ready}, 32'd1);
        check("rd2_c5_data", read_data, 32'h56781234);
        mem_read_en = 1'b0;
        tick();
        check("rd2_c6_ready", {31'd0, ready}, 32'd0);

`ifndef SRAM_CTRL_POSTED_WRITE_EN
        // Read and write together: treated as a write
        address = 32'd1040; write_data = 32'hCAFEF00D;
        mem_read_en = 1'b1; mem_write_en = 1'b1;
        tick();
        check("rw_c1_oe", {31'd0, sram_dq_oe}, 32'd1);
        check("rw_c1_we_n", {31'd0, sram_we_n}, 32'd0);
        check("rw_c1_addr", {14'd0, sram_addr}, 32'd8);
        for (int i = 0; i < 4; i++) tick();
        check("rw_c5_ready", {31'd0, ready}, 32'd1);
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        tick();
        check("rw_read_data_kept", read_data, 32'h56781234);
        check("rw_mem_lo", {16'd0, sram_mem[8]}, 32'h0000F00D);
        check("rw_mem_hi", {16'd0, sram_mem[9]}, 32'h0000CAFE);

        // Reset during HIGH of a write
        address = 32'd1032; write_data = 32'h11112222; mem_write_en = 1'b1;
        tick(); tick(); tick();
        check("rstw_c3_we_n", {31'd0, sram_we_n}, 32'd0);
        check("rstw_c3_addr", {14'd0, sram_addr}, 32'd5);
        rst_n = 1'b0;
        #1;
        check("rstw_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rstw_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rstw_ready", {31'd0, ready}, 32'd0);
        check("rstw_stall_idle", {31'd0, stall}, 32'd1);
        mem_write_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        // Low half was already strobed before the reset; high half was not.
        address = 32'd1032; mem_read_en = 1'b1;
        #1;
        check("rstr_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        check("rstr_c1_addr", {14'd0, sram_addr}, 32'd4);
        for (int i = 0; i < 4; i++) tick();
        check("rstr_c5_ready", {31'd0, ready}, 32'd1);
        check("rstr_c5_data", read_data, 32'hDEAD2222);
        mem_read_en = 1'b0;
        tick();
`else
        // Posted write to 1024 followed by a read of the same word
        address = 32'd1024; write_data = 32'hA5A55A5A; mem_write_en = 1'b1;
        #1;
        check("pw_c0_stall", {31'd0, stall}, 32'd0);
        check("pw_c0_ready", {31'd0, ready}, 32'd1);
        tick();
        mem_write_en = 1'b0; mem_read_en = 1'b1; address = 32'd1024;
        #1;
        check("pw_c1_stall", {31'd0, stall}, 32'd1);
        check("pw_c1_ready", {31'd0, ready}, 32'd0);
        n = 0;
        while (!ready && n < 30) begin
            tick();
            n++;
        end
        check("pw_rd_ready", {31'd0, ready}, 32'd1);
        check("pw_rd_latency", n, 32'd9);
        check("pw_rd_data", read_data, 32'hA5A55A5A);
        mem_read_en = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
